ps2_event_decoder: RTL and testbench

PS2_EVENT_DECODER -- requirements
Module: ps2_event_decoder

---
 rtl/ps2_pkg.sv | 49 ++++
 rtl/ps2_evt_fifo.sv | 82 ++++++++
 rtl/ps2_event_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_event_decoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 event decoder.
// Holds the event record, the prefix FSM state type, the prefix byte values,
// the list of controller status bytes ignored in IDLE, and the modifier codes.
package ps2_pkg;

    // Decoded key event as stored in the event FIFO.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [2:0] {
        StIdle,
        StGotE0,
        StGotF0,
        StGotE0F0,
        StSkip
    } ps2_state_e;

    localparam logic [7:0] CodeE0 = 8'hE0;
    localparam logic [7:0] CodeE1 = 8'hE1;
    localparam logic [7:0] CodeF0 = 8'hF0;

    // Modifier scan codes (set 2).
    localparam logic [7:0] CodeLshift = 8'h12;
    localparam logic [7:0] CodeRshift = 8'h59;
    localparam logic [7:0] CodeCtrl   = 8'h14;
    localparam logic [7:0] CodeAlt    = 8'h11;

    // Bit positions inside mods = {alt, ctrl, rshift, lshift}.
    localparam int unsigned ModLshift = 0;
    localparam int unsigned ModRshift = 1;
    localparam int unsigned ModCtrl   = 2;
    localparam int unsigned ModAlt    = 3;

    // Keyboard status/acknowledge bytes that never start an event.
    function automatic logic is_drop_code(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_drop_code = 1'b1;
            default:                                  is_drop_code = 1'b0;
        endcase
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        is_prefix = (b == CodeE0) || (b == CodeE1) || (b == CodeF0);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event FIFO for the PS/2 decoder.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   push, push_data write request and event to store
//   push_drop       pulses when a push is refused because the FIFO is full
//   evt_valid       head entry present
//   evt_ready       consumer takes the head entry (pop when evt_valid=1)
//   head            head entry, forced to zero while empty
//   count           current occupancy, 0..DEPTH
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  ps2_evt_t                 push_data,
    output logic                     push_drop,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output ps2_evt_t                 head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    ps2_evt_t      mem_q [DEPTH];

    logic pop;
    logic push_ok;

    assign pop     = (count_q != '0) && evt_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push_ok = push && ((count_q < Full) || pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    assign evt_valid = (count_q != '0);
    assign head      = evt_valid ? mem_q[rptr_q] : '0;
    assign push_drop = push && !push_ok;
    assign count     = count_q;

endmodule

// File: rtl/ps2_event_decoder.sv
// PS/2 scan-code set 2 event decoder.
// Turns a stream of received bytes into key events {code, ext, brk}, tracks
// modifier state and queues events in a FIFO.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   byte_valid, byte_data, byte_err   received byte strobe, value, error flag
//   evt_valid, evt_ready              FIFO head handshake
//   evt_code, evt_ext, evt_brk        FIFO head event
//   mods                              {alt, ctrl, rshift, lshift}
//   overflow                          sticky: an event was dropped on a full FIFO
//   err_cnt                           saturating count of error bytes
//   fifo_count                        FIFO occupancy
module ps2_event_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SKIP_LEN = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    input  logic                     byte_err,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [7:0]               evt_code,
    output logic                     evt_ext,
    output logic                     evt_brk,
    output logic [3:0]               mods,
    output logic                     overflow,
    output logic [7:0]               err_cnt,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned SkipW = (SKIP_LEN > 1) ? $clog2(SKIP_LEN + 1) : 1;

    ps2_state_e       state_q, state_d;
    logic [SkipW-1:0] skip_q, skip_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [3:0]       mods_q, mods_d;
    logic             overflow_q, overflow_d;

    logic     byte_ok;
    logic     byte_bad;
    logic     skip_last;
    logic     evt_push;
    ps2_evt_t evt_new;
    ps2_evt_t evt_head;
    logic     push_drop;

    assign byte_ok   = byte_valid && !byte_err;
    assign byte_bad  = byte_valid && byte_err;
    assign skip_last = (skip_q <= SkipW'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            skip_q     <= '0;
            err_cnt_q  <= '0;
            mods_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            err_cnt_q  <= err_cnt_d;
            mods_q     <= mods_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (byte_bad) begin
            state_d = StIdle;
            skip_d  = '0;
        end else if (byte_ok) begin
            unique case (state_q)
                StIdle: begin
                    if (byte_data == CodeE0) begin
                        state_d = StGotE0;
                    end else if (byte_data == CodeF0) begin
                        state_d = StGotF0;
                    end else if (byte_data == CodeE1) begin
                        state_d = StSkip;
                        skip_d  = SkipW'(SKIP_LEN);
                    end
                end
                StGotE0: begin
                    state_d = (byte_data == CodeF0) ? StGotE0F0 : StIdle;
                end
                StGotF0, StGotE0F0: begin
                    state_d = StIdle;
                end
                StSkip: begin
                    if (skip_last) begin
                        state_d = StIdle;
                        skip_d  = '0;
                    end else begin
                        skip_d = skip_q - SkipW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    skip_d  = '0;
                end
            endcase
        end
    end

    // Output logic: event generation, modifiers, error and overflow tracking.
    always_comb begin
        evt_push   = 1'b0;
        evt_new    = '0;
        mods_d     = mods_q;
        err_cnt_d  = err_cnt_q;
        overflow_d = overflow_q | push_drop;

        if (byte_bad && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        if (byte_ok) begin
            unique case (state_q)
                StIdle: begin
                    if (!is_prefix(byte_data) && !is_drop_code(byte_data)) begin
                        evt_push = 1'b1;
                        evt_new  = '{ext: 1'b0, brk: 1'b0, code: byte_data};
                    end
                end
                StGotE0: begin
                    if (byte_data != CodeF0) begin
                        evt_push = 1'b1;
                        evt_new  = '{ext: 1'b1, brk: 1'b0, code: byte_data};
                    end
                end
                StGotF0: begin
                    if (!is_prefix(byte_data)) begin
                        evt_push = 1'b1;
                        evt_new  = '{ext: 1'b0, brk: 1'b1, code: byte_data};
                    end
                end
                StGotE0F0: begin
                    if (!is_prefix(byte_data)) begin
                        evt_push = 1'b1;
                        evt_new  = '{ext: 1'b1, brk: 1'b1, code: byte_data};
                    end
                end
                StSkip: begin
                    // Pause/Break: report once when the skipped run ends.
                    if (skip_last) begin
                        evt_push = 1'b1;
                        evt_new  = '{ext: 1'b1, brk: 1'b0, code: CodeE1};
                    end
                end
                default: ;
            endcase
        end

        // Modifiers follow every completed event, whether or not the FIFO keeps it.
        if (evt_push) begin
            if (evt_new.code == CodeLshift && !evt_new.ext) begin
                mods_d[ModLshift] = !evt_new.brk;
            end
            if (evt_new.code == CodeRshift && !evt_new.ext) begin
                mods_d[ModRshift] = !evt_new.brk;
            end
            if (evt_new.code == CodeCtrl) begin
                mods_d[ModCtrl] = !evt_new.brk;
            end
            if (evt_new.code == CodeAlt) begin
                mods_d[ModAlt] = !evt_new.brk;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (evt_push),
        .push_data (evt_new),
        .push_drop (push_drop),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .head      (evt_head),
        .count     (fifo_count)
    );

    assign evt_code = evt_head.code;
    assign evt_ext  = evt_head.ext;
    assign evt_brk  = evt_head.brk;
    assign mods     = mods_q;
    assign overflow = overflow_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ps2_event_decoder.sv
module tb_ps2_event_decoder;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned SKIP_LEN = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_err = 1'b0;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic [3:0] mods;
    logic       overflow;
    logic [7:0] err_cnt;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entries are {ext, brk, code}.
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    ps2_event_decoder #(
        .DEPTH    (DEPTH),
        .SKIP_LEN (SKIP_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_brk    (evt_brk),
        .mods       (mods),
        .overflow   (overflow),
        .err_cnt    (err_cnt),
        .fifo_count (fifo_count)
    );

    // Compare every popped head against the scoreboard.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            logic [9:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got=%h required=none",
                         {evt_ext, evt_brk, evt_code});
            end else begin
                e = exp_q.pop_front();
                if ({evt_ext, evt_brk, evt_code} !== e) begin
                    failures++;
                    $display("FAIL evt_head got=%h required=%h",
                             {evt_ext, evt_brk, evt_code}, e);
                end
            end
        end
    end

    // Each byte occupies exactly one cycle; consecutive calls are back-to-back.
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_err   = 1'b0;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_err(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_err   = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
    endtask

    task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
        exp_q.push_back({ext, brk, code});
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h1C;
        evt_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 100; i++) begin
            if (fifo_count == 0 && exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (fifo_count !== 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got_count=%0d pending=%0d required=0", name, fifo_count,
                     exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 8;
        if (evt_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", evt_valid); end
        if (fifo_count !== 0) begin failures++; $display("FAIL rst_count got=%0d required=0", fifo_count); end
        if (mods !== 4'b0) begin failures++; $display("FAIL rst_mods got=%b required=0000", mods); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b required=0", overflow); end
        if (err_cnt !== 8'd0) begin failures++; $display("FAIL rst_err got=%0d required=0", err_cnt); end
        if (evt_code !== 8'h00) begin failures++; $display("FAIL rst_code got=%h required=00", evt_code); end
        if (evt_ext !== 1'b0) begin failures++; $display("FAIL rst_ext got=%b required=0", evt_ext); end
        if (evt_brk !== 1'b0) begin failures++; $display("FAIL rst_brk got=%b required=0", evt_brk); end
    endtask

    task automatic test_make_break();
        evt_ready = 1'b1;
        expect_evt(1'b0, 1'b0, 8'h1C);
        send_byte(8'h1C);
        checks++;
        if (evt_valid !== 1'b1) begin failures++; $display("FAIL make_latency got=%b required=1", evt_valid); end
        send_byte(8'hF0);
        checks++;
        if (evt_valid !== 1'b0) begin failures++; $display("FAIL prefix_no_evt got=%b required=0", evt_valid); end
        expect_evt(1'b0, 1'b1, 8'h1C);
        send_byte(8'h1C);
        checks++;
        if (evt_valid !== 1'b1) begin failures++; $display("FAIL break_latency got=%b required=1", evt_valid); end
        wait_empty("make_break");
    endtask

    task automatic test_extended();
        expect_evt(1'b1, 1'b0, 8'h75);
        send_byte(8'hE0);
        send_byte(8'h75);
        expect_evt(1'b1, 1'b1, 8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        wait_empty("extended");
        checks++;
        if (mods !== 4'b0) begin failures++; $display("FAIL ext_mods got=%b required=0000", mods); end
    endtask

    task automatic test_skip();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) begin
            if (i == 7) expect_evt(1'b1, 1'b0, 8'hE1);
            send_byte(seq[i]);
        end
        wait_empty("skip");
        checks++;
        if (mods !== 4'b0) begin failures++; $display("FAIL skip_mods got=%b required=0000", mods); end
    endtask

    task automatic test_mods();
        expect_evt(1'b0, 1'b0, 8'h12);
        send_byte(8'h12);
        checks++;
        if (mods !== 4'b0001) begin failures++; $display("FAIL mods_lshift got=%b required=0001", mods); end
        expect_evt(1'b0, 1'b0, 8'h14);
        send_byte(8'h14);
        checks++;
        if (mods !== 4'b0101) begin failures++; $display("FAIL mods_ctrl got=%b required=0101", mods); end
        expect_evt(1'b0, 1'b1, 8'h12);
        send_byte(8'hF0);
        send_byte(8'h12);
        checks++;
        if (mods !== 4'b0100) begin failures++; $display("FAIL mods_release got=%b required=0100", mods); end
        expect_evt(1'b1, 1'b0, 8'h11);
        send_byte(8'hE0);
        send_byte(8'h11);
        expect_evt(1'b0, 1'b1, 8'h14);
        send_byte(8'hF0);
        send_byte(8'h14);
        checks++;
        if (mods !== 4'b1000) begin failures++; $display("FAIL mods_alt got=%b required=1000", mods); end
        wait_empty("mods");
    endtask

    task automatic test_drop_codes();
        logic [7:0] drops [6];
        drops = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        for (int i = 0; i < 6; i++) send_byte(drops[i]);
        checks++;
        if (fifo_count !== 0 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_codes got_count=%0d required=0", fifo_count);
        end
        // Still in IDLE afterwards.
        expect_evt(1'b0, 1'b0, 8'h1C);
        send_byte(8'h1C);
        // Drop list does not apply after E0.
        expect_evt(1'b1, 1'b0, 8'hAA);
        send_byte(8'hE0);
        send_byte(8'hAA);
        wait_empty("drop_codes");
    endtask

    task automatic test_back_to_back_overflow();
        evt_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            expect_evt(1'b0, 1'b0, 8'h20 + 8'(i));
            send_byte(8'h20 + 8'(i));
        end
        checks++;
        if (fifo_count !== ($clog2(DEPTH) + 1)'(DEPTH) || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill got_count=%0d ovf=%b required=%0d/0", fifo_count, overflow, DEPTH);
        end
        // Push and pop together while full.
        evt_ready = 1'b1;
        expect_evt(1'b0, 1'b0, 8'h30);
        send_byte(8'h30);
        evt_ready = 1'b0;
        checks++;
        if (fifo_count !== ($clog2(DEPTH) + 1)'(DEPTH) || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop got_count=%0d ovf=%b required=%0d/0", fifo_count,
                     overflow, DEPTH);
        end
        send_byte(8'h31);
        checks++;
        if (fifo_count !== ($clog2(DEPTH) + 1)'(DEPTH) || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow got_count=%0d ovf=%b required=%0d/1", fifo_count, overflow,
                     DEPTH);
        end
        evt_ready = 1'b1;
        wait_empty("overflow");
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b required=1", overflow); end
    endtask

    task automatic test_errors();
        send_byte(8'hF0);
        send_err(8'h1C);
        expect_evt(1'b0, 1'b0, 8'h1C);
        send_byte(8'h1C);
        checks++;
        if (err_cnt !== 8'd1) begin failures++; $display("FAIL err_cnt got=%0d required=1", err_cnt); end
        // Error aborts a skip run.
        send_byte(8'hE1);
        send_byte(8'h14);
        send_err(8'h77);
        expect_evt(1'b0, 1'b0, 8'h1C);
        send_byte(8'h1C);
        wait_empty("err");
        checks++;
        if (err_cnt !== 8'd2) begin failures++; $display("FAIL err_cnt2 got=%0d required=2", err_cnt); end
        // Reset in the middle of an E0 sequence.
        send_byte(8'hE0);
        apply_reset();
        checks++;
        if (err_cnt !== 8'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear got_err=%0d ovf=%b required=0/0", err_cnt, overflow);
        end
        expect_evt(1'b0, 1'b0, 8'h75);
        send_byte(8'h75);
        wait_empty("midrst");
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 300; i++) send_err(8'h55);
        checks++;
        if (err_cnt !== 8'd255) begin failures++; $display("FAIL err_sat got=%0d required=255", err_cnt); end
        checks++;
        if (fifo_count !== 0) begin failures++; $display("FAIL err_no_evt got=%0d required=0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_skip();
        test_mods();
        test_drop_codes();
        test_back_to_back_overflow();
        test_errors();
        test_err_saturate();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
